// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared constants and types for the PC redirect controller.
// Holds the next-PC select encodings, the branch funct3 codes and the
// redirect FSM state enum.

package pc_ctrl_pkg;

    // Next-PC mux select encodings
    localparam logic [1:0] PC_SEL_PLUS4    = 2'b00;
    localparam logic [1:0] PC_SEL_IMM      = 2'b01;
    localparam logic [1:0] PC_SEL_ALU      = 2'b10;  // reserved for trap logic
    localparam logic [1:0] PC_SEL_ALU_MASK = 2'b11;

    // RV32I conditional branch funct3 codes
    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    // Width of the flush down-counter (FLUSH_CYCLES is at most 7)
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_ctrl_branch_cond.sv
// branch_cond: purely combinational branch resolution. Maps the branch
// funct3 and the ALU comparison flags to a taken indication. The funct3
// codes 010 and 011 are not branches and resolve as not taken.

module branch_cond
    import pc_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    output logic       taken
);

    // Select the comparison flag (or its inverse) named by funct3
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        taken = 1'b0;
        case (funct3)
            FUNCT3_BEQ:  taken = alu_zero;
            FUNCT3_BNE:  taken = ~alu_zero;
            FUNCT3_BLT:  taken = alu_lt;
            FUNCT3_BGE:  taken = ~alu_lt;
            FUNCT3_BLTU: taken = alu_ltu;
            FUNCT3_BGEU: taken = ~alu_ltu;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: resolves control flow for the instruction in EX, holds
// the resulting next-PC select until fetch accepts it, then keeps flush
// asserted for FLUSH_CYCLES further cycles to squash wrong-path stages.
// All outputs are registered; there is no input-to-output comb path.
// Optional build macro PCCTL_STATS_EN adds branch/redirect counters.

module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jal,
    input  logic        ex_jalr,
    input  logic [2:0]  ex_funct3,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    input  logic        fetch_ready,
    output logic        redirect_valid,
    output logic [1:0]  pc_sel,
    output logic        flush
`ifdef PCCTL_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_redirects
`endif
);

    // Counter value loaded when a redirect is consumed
    localparam logic [CNT_W-1:0] CNT_INIT =
        (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;

    pc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       target_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [1:0]       pc_sel_q, pc_sel_d;
    logic             flush_q, flush_d;
    logic             br_taken;

    branch_cond u_branch_cond (
        .funct3   (ex_funct3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .alu_ltu  (alu_ltu),
        .taken    (br_taken)
    );

    // State register: FSM state, flush counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            pc_sel_q         <= PC_SEL_PLUS4;
            flush_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            pc_sel_q         <= pc_sel_d;
            flush_q          <= flush_d;
        end
    end

    // Next state: redirect decision in IDLE, hand-off in REDIRECT, countdown in FLUSH
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = pc_sel_q;  // in REDIRECT this is the latched target
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_jalr) begin
                        state_d  = REDIRECT;
                        target_d = PC_SEL_ALU_MASK;
                    end else if (ex_jal) begin
                        state_d  = REDIRECT;
                        target_d = PC_SEL_IMM;
                    end else if (ex_branch && br_taken) begin
                        state_d  = REDIRECT;
                        target_d = PC_SEL_IMM;
                    end
                end
            end
            REDIRECT: begin
                if (fetch_ready) begin
                    if (FLUSH_CYCLES > 0) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs for the upcoming state, registered at the same edge as the state
    always_comb begin
        redirect_valid_d = (state_d == REDIRECT);
        pc_sel_d         = (state_d == REDIRECT) ? target_d : PC_SEL_PLUS4;
        flush_d          = (state_d == REDIRECT) || (state_d == FLUSH);
    end

    assign redirect_valid = redirect_valid_q;
    assign pc_sel         = pc_sel_q;
    assign flush          = flush_q;

`ifdef PCCTL_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_redirects_q, stat_redirects_d;

    // A branch is evaluated only in IDLE and only when no jump outranks it
    always_comb begin
        stat_branches_d  = stat_branches_q;
        stat_redirects_d = stat_redirects_q;
        if ((state_q == IDLE) && ex_valid && ex_branch && !ex_jal && !ex_jalr) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if ((state_q == REDIRECT) && fetch_ready) begin
            stat_redirects_d = stat_redirects_q + 32'd1;
        end
    end

    // Statistics counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q  <= '0;
            stat_redirects_q <= '0;
        end else begin
            stat_branches_q  <= stat_branches_d;
            stat_redirects_q <= stat_redirects_d;
        end
    end

    assign stat_branches  = stat_branches_q;
    assign stat_redirects = stat_redirects_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed, table-driven bench for pc_redirect_ctrl.
// u_dut_a uses the default FLUSH_CYCLES=2, u_dut_b uses FLUSH_CYCLES=0;
// both share the same stimulus. Expected outputs are packed {rv, sel, flush}.

module tb_pc_redirect_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid, ex_branch, ex_jal, ex_jalr;
    logic [2:0] ex_funct3;
    logic       alu_zero, alu_lt, alu_ltu, fetch_ready;

    logic       a_rv, a_flush, b_rv, b_flush;
    logic [1:0] a_sel, b_sel;
`ifdef PCCTL_STATS_EN
    logic [31:0] a_stat_br, a_stat_rd, b_stat_br, b_stat_rd;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [3:0] E_IDLE  = 4'b0_00_0;
    localparam logic [3:0] E_FLUSH = 4'b0_00_1;
    localparam logic [3:0] E_IMM   = 4'b1_01_1;
    localparam logic [3:0] E_ALUM  = 4'b1_11_1;

    typedef struct {
        string      name;
        logic       rst, v, br, jal, jalr;
        logic [2:0] f3;
        logic       z, lt, ltu, fr;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    pc_redirect_ctrl #(.FLUSH_CYCLES(2)) u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_jal         (ex_jal),
        .ex_jalr        (ex_jalr),
        .ex_funct3      (ex_funct3),
        .alu_zero       (alu_zero),
        .alu_lt         (alu_lt),
        .alu_ltu        (alu_ltu),
        .fetch_ready    (fetch_ready),
        .redirect_valid (a_rv),
        .pc_sel         (a_sel),
        .flush          (a_flush)
`ifdef PCCTL_STATS_EN
        ,
        .stat_branches  (a_stat_br),
        .stat_redirects (a_stat_rd)
`endif
    );

    pc_redirect_ctrl #(.FLUSH_CYCLES(0)) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_jal         (ex_jal),
        .ex_jalr        (ex_jalr),
        .ex_funct3      (ex_funct3),
        .alu_zero       (alu_zero),
        .alu_lt         (alu_lt),
        .alu_ltu        (alu_ltu),
        .fetch_ready    (fetch_ready),
        .redirect_valid (b_rv),
        .pc_sel         (b_sel),
        .flush          (b_flush)
`ifdef PCCTL_STATS_EN
        ,
        .stat_branches  (b_stat_br),
        .stat_redirects (b_stat_rd)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic br, input logic j,
                         input logic jr, input logic [2:0] f3, input logic z,
                         input logic lt, input logic ltu, input logic fr);
        rst = r; ex_valid = v; ex_branch = br; ex_jal = j; ex_jalr = jr;
        ex_funct3 = f3; alu_zero = z; alu_lt = lt; alu_ltu = ltu; fetch_ready = fr;
    endtask

    // Advance one edge and land 1 time unit after it, away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input logic r, input logic v, input logic br,
                       input logic j, input logic jr, input logic [2:0] f3, input logic z,
                       input logic lt, input logic ltu, input logic fr, input logic [3:0] e);
        vec_t t;
        t.name = nm; t.rst = r; t.v = v; t.br = br; t.jal = j; t.jalr = jr;
        t.f3 = f3; t.z = z; t.lt = lt; t.ltu = ltu; t.fr = fr; t.exp = e;
        vecs.push_back(t);
    endtask

    // Taken decision, then consume (fr=1) and two FLUSH cycles with a taken
    // BEQ held in EX that must be ignored, ending back in IDLE
    task automatic add_taken(input string nm, input logic br, input logic j, input logic jr,
                             input logic [2:0] f3, input logic z, input logic lt,
                             input logic ltu, input logic [3:0] e);
        add({nm, "_dec"},  0, 1, br, j, jr, f3, z, lt, ltu, 1, e);
        add({nm, "_f1"},   0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 1, E_FLUSH);
        add({nm, "_f2"},   0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 1, E_FLUSH);
        add({nm, "_idle"}, 0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 1, E_IDLE);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        tick();
        tick();

        // ---------------- vector table ----------------
        add("reset",     1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, E_IDLE);
        add("nop",       0, 1, 0, 0, 0, 3'b000, 1, 1, 1, 1, E_IDLE);
        add("bgeu_nt",   0, 1, 1, 0, 0, 3'b111, 0, 0, 1, 1, E_IDLE);
        add_taken("beq",  1, 0, 0, 3'b000, 1, 0, 0, E_IMM);
        add_taken("bne",  1, 0, 0, 3'b001, 0, 0, 0, E_IMM);
        add_taken("blt",  1, 0, 0, 3'b100, 0, 1, 0, E_IMM);
        add_taken("bge",  1, 0, 0, 3'b101, 0, 0, 1, E_IMM);
        add_taken("bltu", 1, 0, 0, 3'b110, 0, 1, 1, E_IMM);
        add_taken("bgeu", 1, 0, 0, 3'b111, 1, 1, 0, E_IMM);
        add("beq_nt",    0, 1, 1, 0, 0, 3'b000, 0, 1, 1, 1, E_IDLE);
        add("bne_nt",    0, 1, 1, 0, 0, 3'b001, 1, 0, 0, 1, E_IDLE);
        add("blt_nt",    0, 1, 1, 0, 0, 3'b100, 1, 0, 1, 1, E_IDLE);
        add("bge_nt",    0, 1, 1, 0, 0, 3'b101, 0, 1, 0, 1, E_IDLE);
        add("bltu_nt",   0, 1, 1, 0, 0, 3'b110, 1, 1, 0, 1, E_IDLE);
        add("f3_010_nt", 0, 1, 1, 0, 0, 3'b010, 1, 1, 1, 1, E_IDLE);
        add("f3_011_nt", 0, 1, 1, 0, 0, 3'b011, 1, 1, 1, 1, E_IDLE);
        add("jal_inval", 0, 0, 1, 1, 1, 3'b000, 1, 0, 0, 1, E_IDLE);
        add_taken("jal",      0, 1, 0, 3'b000, 0, 0, 0, E_IMM);
        add_taken("jalr",     0, 0, 1, 3'b000, 0, 0, 0, E_ALUM);
        add_taken("jal_jalr", 0, 1, 1, 3'b000, 0, 0, 0, E_ALUM);
        add_taken("jalr_br",  1, 0, 1, 3'b000, 1, 0, 0, E_ALUM);
        add_taken("jal_brnt", 1, 1, 0, 3'b010, 0, 0, 0, E_IMM);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].br, vecs[i].jal, vecs[i].jalr,
                  vecs[i].f3, vecs[i].z, vecs[i].lt, vecs[i].ltu, vecs[i].fr);
            tick();
            check(vecs[i].name, {28'd0, a_rv, a_sel, a_flush}, {28'd0, vecs[i].exp});
        end

        // ---------------- JALR held while fetch stalls ----------------
        drive(0, 1, 0, 0, 1, 3'b000, 0, 0, 0, 0);
        tick();
        check("jalr_stall_dec", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_ALUM});
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 0);
            tick();
            check("jalr_stall_hold", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_ALUM});
        end
        drive(0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 1);
        tick();
        check("jalr_stall_f1", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_FLUSH});
        tick();
        check("jalr_stall_f2", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_FLUSH});
        tick();
        check("jalr_stall_idle", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_IDLE});

        // ---------------- reset in REDIRECT, then a normal JAL ----------------
        drive(0, 1, 0, 1, 0, 3'b000, 0, 0, 0, 0);
        tick();
        check("rst_red_dec", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_IMM});
        drive(1, 1, 0, 1, 0, 3'b000, 0, 0, 0, 1);
        tick();
        check("rst_red_clear", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_IDLE});
        drive(0, 1, 0, 1, 0, 3'b000, 0, 0, 0, 1);
        tick();
        check("rst_red_jal", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_IMM});
        drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1);
        tick();
        check("rst_red_f1", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_FLUSH});
        tick();
        check("rst_red_f2", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_FLUSH});
        tick();
        check("rst_red_idle", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_IDLE});

        // ---------------- reset in FLUSH abandons the flush ----------------
        drive(0, 1, 0, 1, 0, 3'b000, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1);
        tick();
        check("rst_fl_f1", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_FLUSH});
        drive(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1);
        tick();
        check("rst_fl_clear", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_IDLE});
        drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1);
        tick();
        check("rst_fl_stay", {28'd0, a_rv, a_sel, a_flush}, {28'd0, E_IDLE});

`ifdef PCCTL_STATS_EN
        // ---------------- statistics on the default instance ----------------
        drive(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1);
        tick();
        check("stat_rst_br", a_stat_br, 32'd0);
        check("stat_rst_rd", a_stat_rd, 32'd0);
        drive(0, 1, 1, 0, 0, 3'b111, 0, 0, 1, 1);
        tick();
        check("stat_bgeu_br", a_stat_br, 32'd1);
        check("stat_bgeu_rd", a_stat_rd, 32'd0);
        drive(0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1);
        tick();
        check("stat_beq_br", a_stat_br, 32'd2);
        check("stat_beq_rd", a_stat_rd, 32'd1);
        tick();
        tick();
`endif

        // ---------------- FLUSH_CYCLES=0, back-to-back JALs ----------------
        drive(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1);
        tick();
        check("fc0_reset", {28'd0, b_rv, b_sel, b_flush}, {28'd0, E_IDLE});
        drive(0, 1, 0, 1, 0, 3'b000, 0, 0, 0, 1);
        tick();
        check("fc0_jal1", {28'd0, b_rv, b_sel, b_flush}, {28'd0, E_IMM});
        tick();
        check("fc0_idle1", {28'd0, b_rv, b_sel, b_flush}, {28'd0, E_IDLE});
        tick();
        check("fc0_jal2", {28'd0, b_rv, b_sel, b_flush}, {28'd0, E_IMM});
        drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1);
        tick();
        check("fc0_idle2", {28'd0, b_rv, b_sel, b_flush}, {28'd0, E_IDLE});
        tick();
        check("fc0_idle3", {28'd0, b_rv, b_sel, b_flush}, {28'd0, E_IDLE});
`ifdef PCCTL_STATS_EN
        check("fc0_stat_rd", b_stat_rd, 32'd2);
        check("fc0_stat_br", b_stat_br, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Control-flow redirect controller for the RV32I core. It resolves branch/jump outcomes for the instruction in EX and drives the 2-bit next-PC select consumed by the PC multiplexer. It holds a redirect until fetch accepts it, then flushes wrong-path pipeline stages for a fixed number of cycles.

## Interface
Parameters:
- FLUSH_CYCLES, default 2: cycles `flush` stays asserted after a redirect is consumed; legal range 0..7.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX holds a valid instruction
- ex_branch  in  1  EX instruction is a conditional branch
- ex_jal  in  1  EX instruction is JAL
- ex_jalr  in  1  EX instruction is JALR
- ex_funct3  in  3  branch funct3
- alu_zero  in  1  rs1 == rs2
- alu_lt  in  1  rs1 < rs2, signed
- alu_ltu  in  1  rs1 < rs2, unsigned
- fetch_ready  in  1  PC register accepts a redirect this cycle
- redirect_valid  out  1  registered; `pc_sel` carries a redirect
- pc_sel  out  2  registered; 00 = PC+4, 01 = PC+imm, 10 = ALU result, 11 = ALU result with bit0 cleared
- flush  out  1  registered; squash IF/ID and ID/EX contents

## Operation
- States:
  - IDLE: outputs redirect_valid=0, pc_sel=00, flush=0.
  - REDIRECT: outputs redirect_valid=1, pc_sel held, flush=1.
  - FLUSH: outputs flush=1, redirect_valid=0, pc_sel=00.
- Decision (IDLE only, ex_valid=1). Priority is jalr > jal > branch when several are asserted.
  - jalr → redirect with sel 11.
  - jal → redirect with sel 01.
  - branch taken → redirect with sel 01.
  - Not-taken branch and non-control instructions → stay IDLE, no output change.
- Branch condition by funct3:
  - 000: zero.
  - 001: !zero.
  - 100: lt.
  - 101: !lt.
  - 110: ltu.
  - 111: !ltu.
  - 010 and 011: not taken.
- Transitions:
  - IDLE → REDIRECT on a redirect decision; pc_sel is latched at the same edge.
  - In REDIRECT, a redirect is consumed on an edge where fetch_ready=1:
    - FLUSH_CYCLES>0: go to FLUSH with counter=FLUSH_CYCLES-1.
    - FLUSH_CYCLES=0: go to IDLE.
  - FLUSH: counter decrements each cycle; go to IDLE on the edge where counter==0.
- EX inputs are ignored in REDIRECT and FLUSH because those instructions are wrong-path.
- Select code 10 is never driven by this block. It is reserved for the mux's ALU-target path driven by future trap logic.
- Reset: state=IDLE, counter=0, redirect_valid=0, pc_sel=00, flush=0. Reset mid-REDIRECT or mid-FLUSH abandons the redirect.

## Timing
- Decision at edge N makes outputs valid after edge N (1-cycle latency).
- pc_sel and redirect_valid stay stable until the consuming edge. fetch_ready low stalls indefinitely in REDIRECT.
- Flush length:
  - flush is high in every REDIRECT cycle plus FLUSH_CYCLES FLUSH cycles.
  - With fetch_ready tied high, the minimum total is 1+FLUSH_CYCLES cycles.
- A new decision can be taken in the first IDLE cycle after FLUSH (back-to-back redirects are allowed).
- No combinational path from inputs to outputs.

## Configuration
- PCCTL_STATS_EN defined adds two outputs:
  - stat_branches (32): counts ex_branch decisions evaluated in IDLE, taken or not.
  - stat_redirects (32): counts consuming edges.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: both ports and counters are absent. All other behaviour is identical.

## Structure
- Package pc_ctrl_pkg holds:
  - PC_SEL_PLUS4, PC_SEL_IMM, PC_SEL_ALU and PC_SEL_ALU_MASK constants.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU funct3 constants.
  - The state enum (IDLE, REDIRECT, FLUSH).
- One combinational sub-module, branch_cond: maps funct3 and the alu flags to `taken`. The FSM and counter live in the top module.

## Test plan
- BEQ with alu_zero=1, fetch_ready=1 → next cycle redirect_valid=1 and pc_sel=01. flush is high for 3 cycles, then IDLE.
- BGEU with alu_ltu=1 → not taken; outputs stay 00/0/0. stat_branches increments by 1 when enabled.
- JALR with fetch_ready low for 4 cycles → pc_sel=11 held for 5 cycles, consumed on the first edge with fetch_ready high, then 2 FLUSH cycles.
- jal and jalr asserted together → pc_sel=11. A branch in EX during the FLUSH cycles is ignored.
- rst asserted in REDIRECT → next cycle all outputs 0 and state IDLE. A subsequent JAL is handled normally.
- FLUSH_CYCLES=0 with back-to-back JAL decisions → each gives exactly 1 redirect cycle. stat_redirects=2.
